// File: rtl/fp_reg_file.sv
// Coprocessor-1 floating-point register file.
// 32-bit registers; a double occupies an even/odd pair, with the even register
// holding the high word. Two combinational read ports, one synchronous write
// port, an optional same-cycle write-to-read bypass, and a sticky flag for
// double accesses that use an odd register index.
module fp_reg_file #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isDouble,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [31:0]       rd_data0_0,
  output logic [31:0]       rd_data0_1,
  output logic [31:0]       rd_data1_0,
  output logic [31:0]       rd_data1_1,
  input  logic              wr_en,
  input  logic              wr_double,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data_0,
  input  logic [31:0]       wr_data_1,
  input  logic              align_clr,
  output logic              align_err
);

  logic [31:0]       regs_q [NUM_REGS];
  logic [31:0]       regs_d [NUM_REGS];
  logic              align_err_q;
  logic              align_err_d;

  logic [ADDR_W-1:0] wa_even;
  logic [ADDR_W-1:0] wa_odd;
  logic [ADDR_W-1:0] rd_idx  [4];
  logic [31:0]       rd_word [4];
  logic              align_set;

  // Even/odd halves of the write pair; a misaligned double still uses the even-aligned pair.
  always_comb begin
    wa_even = {wr_addr[ADDR_W-1:1], 1'b0};
    wa_odd  = {wr_addr[ADDR_W-1:1], 1'b1};
  end

  // Next register contents: a single write touches one word, a double write both halves.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      if (wr_double) begin
        regs_d[wa_even] = wr_data_0;
        regs_d[wa_odd]  = wr_data_1;
      end else begin
        regs_d[wr_addr] = wr_data_0;
      end
    end
  end

  // Register array storage; reset clears every word, so nothing in flight survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Word indices per read word: the high word is even-aligned only for doubles, the
  // low word is always the odd partner so it is deterministic for singles too.
  always_comb begin
    rd_idx[0] = isDouble ? {rd_addr0[ADDR_W-1:1], 1'b0} : rd_addr0;
    rd_idx[1] = {rd_addr0[ADDR_W-1:1], 1'b1};
    rd_idx[2] = isDouble ? {rd_addr1[ADDR_W-1:1], 1'b0} : rd_addr1;
    rd_idx[3] = {rd_addr1[ADDR_W-1:1], 1'b1};
  end

  // Read words with optional bypass from the write port; outputs are held at zero during reset.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_word[i] = regs_q[rd_idx[i]];
      if ((BYPASS != 0) && wr_en) begin
        if (wr_double) begin
          if (rd_idx[i] == wa_even) begin
            rd_word[i] = wr_data_0;
          end else if (rd_idx[i] == wa_odd) begin
            rd_word[i] = wr_data_1;
          end
        end else if (rd_idx[i] == wr_addr) begin
          rd_word[i] = wr_data_0;
        end
      end
      if (!rst_n) begin
        rd_word[i] = '0;
      end
    end
  end

  // Drive the read-port outputs.
  always_comb begin
    rd_data0_0 = rd_word[0];
    rd_data0_1 = rd_word[1];
    rd_data1_0 = rd_word[2];
    rd_data1_1 = rd_word[3];
  end

  // Sticky misalignment flag; a new error in the same cycle as a clear keeps it set.
  always_comb begin
    align_set = (isDouble && rd_addr0[0]) ||
                (isDouble && rd_addr1[0]) ||
                (wr_en && wr_double && wr_addr[0]);
    if (align_set) begin
      align_err_d = 1'b1;
    end else if (align_clr) begin
      align_err_d = 1'b0;
    end else begin
      align_err_d = align_err_q;
    end
  end

  // Flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign align_err = align_err_q;

endmodule

// File: tb/tb_fp_reg_file.sv
// Directed bench for fp_reg_file: a vector table stepped one clock per entry, plus
// hand-written sequences for reset-time reads, BYPASS=0 behaviour and asynchronous reset.
module tb_fp_reg_file;

  logic        clk;
  logic        rst_n;
  logic        isDouble;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] rd_data0_0, rd_data0_1, rd_data1_0, rd_data1_1;
  logic [31:0] nb_data0_0, nb_data0_1, nb_data1_0, nb_data1_1;
  logic        wr_en;
  logic        wr_double;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data_0;
  logic [31:0] wr_data_1;
  logic        align_clr;
  logic        align_err;
  logic        nb_align_err;

  int n_total;
  int n_pass;

  fp_reg_file #(.NUM_REGS(32), .ADDR_W(5), .BYPASS(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .isDouble   (isDouble),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_data0_0 (rd_data0_0),
    .rd_data0_1 (rd_data0_1),
    .rd_data1_0 (rd_data1_0),
    .rd_data1_1 (rd_data1_1),
    .wr_en      (wr_en),
    .wr_double  (wr_double),
    .wr_addr    (wr_addr),
    .wr_data_0  (wr_data_0),
    .wr_data_1  (wr_data_1),
    .align_clr  (align_clr),
    .align_err  (align_err)
  );

  fp_reg_file #(.NUM_REGS(32), .ADDR_W(5), .BYPASS(0)) u_nb (
    .clk        (clk),
    .rst_n      (rst_n),
    .isDouble   (isDouble),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_data0_0 (nb_data0_0),
    .rd_data0_1 (nb_data0_1),
    .rd_data1_0 (nb_data1_0),
    .rd_data1_1 (nb_data1_1),
    .wr_en      (wr_en),
    .wr_double  (wr_double),
    .wr_addr    (wr_addr),
    .wr_data_0  (wr_data_0),
    .wr_data_1  (wr_data_1),
    .align_clr  (align_clr),
    .align_err  (nb_align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        dbl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        we;
    logic        wdbl;
    logic [4:0]  wa;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        clr;
    logic [31:0] e00;
    logic [31:0] e01;
    logic [31:0] e10;
    logic [31:0] e11;
    logic        ealign;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input vec_t v);
    isDouble  = v.dbl;
    rd_addr0  = v.a0;
    rd_addr1  = v.a1;
    wr_en     = v.we;
    wr_double = v.wdbl;
    wr_addr   = v.wa;
    wr_data_0 = v.wd0;
    wr_data_1 = v.wd1;
    align_clr = v.clr;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    //            dbl  a0     a1     we   wdbl wa     wd0           wd1           clr  e00           e01           e10           e11           ealign
    vecs[0]  = '{1'b0, 5'd0,  5'd1,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 5'd30, 5'd2,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 5'd3,  5'd2,  1'b1, 1'b0, 5'd3,  32'h3F800000, 32'h0,        1'b0, 32'h3F800000, 32'h3F800000, 32'h0,        32'h3F800000, 1'b0};
    vecs[3]  = '{1'b0, 5'd3,  5'd2,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h3F800000, 32'h3F800000, 32'h0,        32'h3F800000, 1'b0};
    vecs[4]  = '{1'b1, 5'd0,  5'd6,  1'b1, 1'b1, 5'd4,  32'h40090000, 32'h00000001, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b1, 5'd2,  5'd4,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        32'h3F800000, 32'h40090000, 32'h00000001, 1'b0};
    vecs[6]  = '{1'b0, 5'd7,  5'd6,  1'b1, 1'b0, 5'd7,  32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b1, 5'd10, 5'd4,  1'b1, 1'b1, 5'd10, 32'h11111111, 32'h22222222, 1'b0, 32'h11111111, 32'h22222222, 32'h40090000, 32'h00000001, 1'b0};
    vecs[8]  = '{1'b0, 5'd7,  5'd11, 1'b0, 1'b1, 5'd9,  32'hAAAAAAAA, 32'hBBBBBBBB, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22222222, 32'h22222222, 1'b0};
    vecs[9]  = '{1'b1, 5'd8,  5'd10, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        32'h11111111, 32'h22222222, 1'b0};
    vecs[10] = '{1'b1, 5'd5,  5'd10, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h40090000, 32'h00000001, 32'h11111111, 32'h22222222, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 5'd8,  5'd9,  1'b1, 1'b1, 5'd9,  32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b1};
    vecs[13] = '{1'b1, 5'd8,  5'd2,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0,        32'h3F800000, 1'b0};
    vecs[14] = '{1'b1, 5'd0,  5'd3,  1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'h0,        32'h0,        32'h0,        32'h3F800000, 1'b1};
    vecs[15] = '{1'b0, 5'd4,  5'd12, 1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 32'h40090000, 32'h00000001, 32'h0,        32'h0,        1'b0};

    // Reset held: even an active write must not bypass onto the read ports.
    rst_n = 1'b0;
    drive('0);
    wr_en     = 1'b1;
    wr_addr   = 5'd0;
    wr_data_0 = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst r00", rd_data0_0, 32'h0);
    check("rst r11", rd_data1_1, 32'h0);
    check("rst align", {31'b0, align_err}, 32'h0);

    @(negedge clk);
    drive('0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d r00", i), rd_data0_0, vecs[i].e00);
      check($sformatf("v%0d r01", i), rd_data0_1, vecs[i].e01);
      check($sformatf("v%0d r10", i), rd_data1_0, vecs[i].e10);
      check($sformatf("v%0d r11", i), rd_data1_1, vecs[i].e11);
      @(posedge clk);
      #1;
      check($sformatf("v%0d align", i), {31'b0, align_err}, {31'b0, vecs[i].ealign});
    end

    // Bypass vs no-bypass instance, then asynchronous reset in the middle of a write cycle.
    @(negedge clk);
    drive('0);
    isDouble  = 1'b1;
    rd_addr0  = 5'd21;
    rd_addr1  = 5'd4;
    wr_en     = 1'b1;
    wr_addr   = 5'd20;
    wr_data_0 = 32'hCAFEF00D;
    #1;
    check("byp r00", rd_data0_0, 32'hCAFEF00D);
    check("nobyp r00", nb_data0_0, 32'h0);
    check("nobyp r10", nb_data1_0, 32'h40090000);
    @(posedge clk);
    #1;
    check("odd dbl align", {31'b0, align_err}, 32'h1);
    check("nobyp after", nb_data0_0, 32'hCAFEF00D);
    wr_addr   = 5'd4;
    wr_data_0 = 32'h55555555;
    #2;
    rst_n = 1'b0;
    #1;
    check("async r00", rd_data0_0, 32'h0);
    check("async r10", rd_data1_0, 32'h0);
    check("async r11", rd_data1_1, 32'h0);
    check("async align", {31'b0, align_err}, 32'h0);

    @(negedge clk);
    drive('0);
    rst_n    = 1'b1;
    rd_addr0 = 5'd20;
    isDouble = 1'b0;
    #1;
    check("post rst f20", rd_data0_0, 32'h0);
    @(negedge clk);
    isDouble = 1'b1;
    rd_addr1 = 5'd4;
    #1;
    check("post rst f4", rd_data1_0, 32'h0);
    check("post rst f5", rd_data1_1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
